maxnet_arbiter: RTL

MAXNET_ARBITER -- requirements
Module: maxnet_arbiter

---
 rtl/maxnet_pkg.sv | 13 +
 rtl/maxnet_arbiter_if.sv | 40 ++++
 rtl/maxnet_rr_arb.sv | 11 +
 rtl/maxnet_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet job arbiter.
package maxnet_pkg;
    localparam int WORD_W = 32;
    localparam int NUM_IN = 4;
    localparam int A_W    = WORD_W * NUM_IN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;
endpackage

// File: rtl/maxnet_arbiter_if.sv
// Requester, engine and response signals of the Maxnet arbiter; slave is the arbiter side.
interface maxnet_arbiter_if;
    import maxnet_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [WORD_W-1:0] req0_eps;
    logic [A_W-1:0]    req0_a;
    logic              req1_valid;
    logic              req1_ready;
    logic [WORD_W-1:0] req1_eps;
    logic [A_W-1:0]    req1_a;
    logic              eng_start;
    logic [WORD_W-1:0] eng_eps;
    logic [A_W-1:0]    eng_a;
    logic              eng_finish;
    logic [WORD_W-1:0] eng_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_timeout;
    logic              busy;

    modport slave (
        input  req0_valid, req0_eps, req0_a,
        input  req1_valid, req1_eps, req1_a,
        input  eng_finish, eng_out, rsp_ready,
        output req0_ready, req1_ready, eng_start, eng_eps, eng_a,
        output rsp_valid, rsp_id, rsp_data, rsp_timeout, busy
    );

    modport master (
        output req0_valid, req0_eps, req0_a,
        output req1_valid, req1_eps, req1_a,
        output eng_finish, eng_out, rsp_ready,
        input  req0_ready, req1_ready, eng_start, eng_eps, eng_a,
        input  rsp_valid, rsp_id, rsp_data, rsp_timeout, busy
    );
endinterface

// File: rtl/maxnet_rr_arb.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module maxnet_rr_arb (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last,
    output logic o_grant0,
    output logic o_grant1
);
    assign o_grant0 = i_valid0 & (~i_valid1 | i_last);
    assign o_grant1 = i_valid1 & (~i_valid0 | ~i_last);
endmodule

// File: rtl/maxnet_arbiter.sv
// Shares one Maxnet engine between two requesters, one job in flight, with a WAIT timeout.
// state | meaning: IDLE grant a job | START pulse eng_start | WAIT await finish/timeout | RESP hold result
module maxnet_arbiter
    import maxnet_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    maxnet_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_eps;
    logic [A_W-1:0]    r_a;
    logic [WORD_W-1:0] r_rsp_data;
    logic              r_rsp_timeout;
    logic              r_id;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_fin;
    logic              w_tmo;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_start;
    logic              w_rsp_valid;
    logic              w_busy;

    maxnet_rr_arb u_rr (
        .i_valid0 (bus.req0_valid),
        .i_valid1 (bus.req1_valid),
        .i_last   (r_last),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    // The first WAIT cycle (count 0) may still see the previous job's finish level.
    assign w_fin = (r_state == S_WAIT) && (r_cnt != '0) && bus.eng_finish;
    assign w_tmo = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_comb begin
        w_next      = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_start     = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_grant0 || w_grant1) begin
                    w_ready0 = w_grant0;
                    w_ready1 = w_grant1;
                    w_next   = S_START;
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (w_fin || w_tmo) w_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_eps         <= '0;
            r_a           <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_id          <= 1'b0;
            r_last        <= 1'b1;
            r_cnt         <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_eps <= w_grant1 ? bus.req1_eps : bus.req0_eps;
                        r_a   <= w_grant1 ? bus.req1_a   : bus.req0_a;
                        r_id  <= w_grant1;
                    end
                end
                S_START: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Finish takes priority over a coincident timeout.
                    if (w_fin) begin
                        r_rsp_data    <= bus.eng_out;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_tmo) begin
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) r_last <= r_id;
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.eng_start   = w_start;
    assign bus.eng_eps     = r_eps;
    assign bus.eng_a       = r_a;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_id      = r_id;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = w_busy;
endmodule
